psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Downstream stage of the 16-bit approximate CLA adder in the CNN datapath.
- Takes each adder result ({cout,sum}, 17 bits unsigned) and accumulates LEN consecutive results into one partial sum, e.g. one 3x3 kernel window.
- Emits the saturated partial sum with an overflow flag over a valid/ready output, and holds one finished result while the next group accumulates.

Parameters:
- DATA_W, 16, adder sum width; operand is DATA_W+1 bits including carry-out.
- ACC_W, 24, accumulator and output width; must be >= DATA_W+1.
- LEN, 9, adder results per group; legal range 1..255.

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort of the group currently accumulating
- in_valid  in  1  adder result valid
- in_ready  out  1  block can accept an adder result
- in_sum  in  DATA_W  adder sum
- in_cout  in  1  adder carry-out
- out_valid  out  1  finished partial sum available
- out_ready  in  1  consumer accepts the partial sum
- out_data  out  ACC_W  saturated partial sum
- out_ovf  out  1  saturation occurred in this group
- busy  out  1  group in progress (cnt != 0)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all registers go to 0 immediately: acc, cnt, ovf_sticky, out_valid, out_data, out_ovf. busy=0. in_ready goes to 1 once rst_n is released.
- Operand: x = zero-extend({in_cout,in_sum}) to ACC_W+1 bits. Accept = in_valid & in_ready.
- On accept:
  - base = 0 when cnt==0, else acc.
  - s = base + x, computed in ACC_W+1 bits.
  - If s > 2^ACC_W-1, the result is 2^ACC_W-1 and ovf is set.
  - ovf_sticky is cleared at the first term of each group.
- Non-final accept (cnt < LEN-1): acc <= result, cnt <= cnt+1.
- Final accept (cnt == LEN-1):
  - out_data <= result; out_ovf <= ovf_sticky | this-term ovf.
  - out_valid <= 1; cnt <= 0; acc <= 0; ovf_sticky <= 0.
  - Latency: result appears the cycle after the final accept.
- LEN=1: every accept is final.
- Output hold: out_data, out_ovf and out_valid stay stable while out_valid & !out_ready. out_valid falls the cycle after out_valid & out_ready, unless a new final accept happens in that same cycle. In that case out_data and out_ovf take the new group and out_valid stays 1.
- in_ready (combinational) = !clear & !(cnt==LEN-1 & out_valid & !out_ready).
  - The next group may accumulate up to its final term while an older result is pending.
  - in_ready depends combinationally on out_ready. No path exists from in_valid to in_ready.
- clear: same cycle sets in_ready=0 and ignores inputs. Next cycle acc=0, cnt=0, ovf_sticky=0. The pending output register and out_valid are unaffected.
- Reset asserted mid-group or with an output pending: everything is discarded, with no partial output.
- busy = (cnt != 0).
- in_sum/in_cout are don't-care when in_valid=0 and must not affect state.

Test Plan:
- Default params, out_ready=1: 9 accepts of in_cout=1,in_sum=0x0000 -> out_data=0x090000, out_ovf=0, out_valid high 1 cycle, 1 cycle after the 9th accept.
- ACC_W=20: 9 accepts of {1,0xFFFF} (131071 each). Running sum passes 1048575 at term 9 (1179639) -> out_data=0xFFFFF, out_ovf=1. The next group of 9x0x0001 -> out_data=9, out_ovf=0 (sticky cleared).
- Backpressure with out_ready=0:
  - Group A = 9x1 -> out_data=9 held.
  - Group B = 9x2: terms 1-8 accepted. On term 9, in_ready=0 and busy=1.
  - Raise out_ready for 1 cycle -> A consumed and B's final term accepted the same cycle. Next cycle out_valid=1, out_data=18.
- clear after 4 terms of 0x0100, then 9x0x0001 -> out_data=9; the earlier 0x400 is never output. in_ready=0 in the clear cycle.
- rst_n low asynchronously mid-group (cnt=5) with an output pending -> all outputs 0 without a clock edge. After release, 9x0x0003 -> out_data=27.
- LEN=1: accepts of 0x1234 and then {1,0x0000} back-to-back with out_ready=1 -> out_data 0x1234 then 0x10000 on consecutive cycles, out_valid continuously 1.

Source files
------------

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums LEN consecutive {cout,sum} adder results into one
// saturated partial sum. A one-entry output register holds the finished sum
// with its overflow flag while the next group accumulates behind it.
module psum_accumulator #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              busy
);

    // LEN is at most 255, so the term index always fits in 8 bits
    localparam int                CNT_W = 8;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(LEN - 1);
    localparam logic [ACC_W-1:0]  SAT   = '1;

    logic [ACC_W-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             sticky_q, sticky_d;
    logic             ovalid_q, ovalid_d;
    logic [ACC_W-1:0] odata_q,  odata_d;
    logic             oovf_q,   oovf_d;

    logic [ACC_W:0]   x_ext;
    logic [ACC_W:0]   base_ext;
    logic [ACC_W:0]   sum_ext;
    logic             first;
    logic             is_last;
    logic             term_ovf;
    logic [ACC_W-1:0] term_res;
    logic             grp_ovf;
    logic             accept;

    // One saturating add per accepted term; the first term of a group starts
    // from zero so a stale accumulator never leaks into the next group.
    always_comb begin
        first    = (cnt_q == '0);
        is_last  = (cnt_q == LAST);
        x_ext    = {{(ACC_W - DATA_W){1'b0}}, in_cout, in_sum};
        base_ext = first ? '0 : {1'b0, acc_q};
        sum_ext  = base_ext + x_ext;
        term_ovf = sum_ext[ACC_W];
        term_res = term_ovf ? SAT : sum_ext[ACC_W-1:0];
        grp_ovf  = (!first & sticky_q) | term_ovf;
        // Only the final term needs the output slot, so earlier terms keep
        // flowing while a finished result is still waiting downstream.
        in_ready = !clear & !(is_last & ovalid_q & !out_ready);
        accept   = in_valid & in_ready;
    end

    // Next-state for the group accumulator and the output holding register
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        oovf_d   = oovf_q;

        if (ovalid_q && out_ready) begin
            ovalid_d = 1'b0;
        end

        if (clear) begin
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (accept) begin
            if (is_last) begin
                // A new final term wins over a same-cycle drain of the slot
                odata_d  = term_res;
                oovf_d   = grp_ovf;
                ovalid_d = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
                sticky_d = 1'b0;
            end else begin
                acc_d    = term_res;
                cnt_d    = cnt_q + 1'b1;
                sticky_d = grp_ovf;
            end
        end
    end

    // State registers; reset discards any partial group and pending output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            oovf_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            oovf_q   <= oovf_d;
        end
    end

    assign out_valid = ovalid_q;
    assign out_data  = odata_q;
    assign out_ovf   = oovf_q;
    assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: three instances (default, ACC_W=20, LEN=1),
// directed scenarios plus randomized traffic against a group-sum model.
module tb_psum_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       clear_v    = '0;
    logic [2:0]       in_valid_v = '0;
    logic [2:0]       in_cout_v  = '0;
    logic [2:0]       out_ready_v = '0;
    logic [2:0][15:0] in_sum_v   = '0;

    logic        a_rdy, b_rdy, c_rdy, a_ov, b_ov, c_ov, a_of, b_of, c_of, a_bz, b_bz, c_bz;
    logic [23:0] a_data, c_data;
    logic [19:0] b_data;
    logic [2:0]  rdy_v, valid_v, ovf_v, busy_v;
    assign rdy_v   = {c_rdy, b_rdy, a_rdy};
    assign valid_v = {c_ov, b_ov, a_ov};
    assign ovf_v   = {c_of, b_of, a_of};
    assign busy_v  = {c_bz, b_bz, a_bz};

    int n_cmp = 0;
    int n_err = 0;

    psum_accumulator #(.DATA_W(16), .ACC_W(24), .LEN(9)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_v[0]), .in_valid(in_valid_v[0]),
        .in_ready(a_rdy), .in_sum(in_sum_v[0]), .in_cout(in_cout_v[0]),
        .out_valid(a_ov), .out_ready(out_ready_v[0]), .out_data(a_data),
        .out_ovf(a_of), .busy(a_bz));

    psum_accumulator #(.DATA_W(16), .ACC_W(20), .LEN(9)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_v[1]), .in_valid(in_valid_v[1]),
        .in_ready(b_rdy), .in_sum(in_sum_v[1]), .in_cout(in_cout_v[1]),
        .out_valid(b_ov), .out_ready(out_ready_v[1]), .out_data(b_data),
        .out_ovf(b_of), .busy(b_bz));

    psum_accumulator #(.DATA_W(16), .ACC_W(24), .LEN(1)) u_c (
        .clk(clk), .rst_n(rst_n), .clear(clear_v[2]), .in_valid(in_valid_v[2]),
        .in_ready(c_rdy), .in_sum(in_sum_v[2]), .in_cout(in_cout_v[2]),
        .out_valid(c_ov), .out_ready(out_ready_v[2]), .out_data(c_data),
        .out_ovf(c_of), .busy(c_bz));

    function automatic logic [23:0] get_data(input int d);
        case (d)
            0:       return a_data;
            1:       return {4'b0, b_data};
            default: return c_data;
        endcase
    endfunction

    // Present one term and hold it until accepted (bounded wait).
    // Entered and left at posedge+1.
    task automatic send(input int d, input logic [15:0] s, input logic c);
        int t = 0;
        in_valid_v[d] = 1'b1; in_sum_v[d] = s; in_cout_v[d] = c;
        #1;
        while (!rdy_v[d] && t < 50) begin @(posedge clk); #2; t++; end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: inst %0d in_ready stuck at %0b, required 1", d, rdy_v[d]);
        end
        @(posedge clk); #1;
        in_valid_v[d] = 1'b0;
        in_sum_v[d] = 16'($urandom); in_cout_v[d] = 1'($urandom);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (valid_v !== 3'b000) begin n_err++; $display("FAIL reset_out_valid: got %b required 000", valid_v); end
        n_cmp++; if (ovf_v !== 3'b000) begin n_err++; $display("FAIL reset_out_ovf: got %b required 000", ovf_v); end
        n_cmp++; if (busy_v !== 3'b000) begin n_err++; $display("FAIL reset_busy: got %b required 000", busy_v); end
        n_cmp++; if (a_data !== 24'h0 || b_data !== 20'h0 || c_data !== 24'h0) begin
            n_err++; $display("FAIL reset_out_data: got %h %h %h required 0", a_data, b_data, c_data); end
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (rdy_v !== 3'b111) begin n_err++; $display("FAIL reset_in_ready: got %b required 111", rdy_v); end
    endtask

    task automatic test_basic();
        out_ready_v[0] = 1'b1;
        for (int i = 0; i < 8; i++) send(0, 16'h0000, 1'b1);
        n_cmp++; if (a_bz !== 1'b1 || a_ov !== 1'b0) begin n_err++; $display("FAIL basic_mid: busy=%b valid=%b required 1 0", a_bz, a_ov); end
        send(0, 16'h0000, 1'b1);
        n_cmp++; if (a_ov !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b required 1", a_ov); end
        n_cmp++; if (a_data !== 24'h090000) begin n_err++; $display("FAIL basic_data: got %h required 090000", a_data); end
        n_cmp++; if (a_of !== 1'b0 || a_bz !== 1'b0) begin n_err++; $display("FAIL basic_ovf_busy: ovf=%b busy=%b required 0 0", a_of, a_bz); end
        @(posedge clk); #1;
        n_cmp++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %b required 0", a_ov); end
    endtask

    task automatic test_saturation();
        out_ready_v[1] = 1'b1;
        for (int i = 0; i < 9; i++) send(1, 16'hFFFF, 1'b1);
        n_cmp++; if (b_ov !== 1'b1 || b_data !== 20'hFFFFF || b_of !== 1'b1) begin
            n_err++; $display("FAIL sat_group: valid=%b data=%h ovf=%b required 1 fffff 1", b_ov, b_data, b_of); end
        for (int i = 0; i < 9; i++) send(1, 16'h0001, 1'b0);
        n_cmp++; if (b_ov !== 1'b1 || b_data !== 20'd9 || b_of !== 1'b0) begin
            n_err++; $display("FAIL sat_next_group: valid=%b data=%h ovf=%b required 1 9 0", b_ov, b_data, b_of); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready_v[0] = 1'b0;
        for (int i = 0; i < 9; i++) send(0, 16'd1, 1'b0);
        n_cmp++; if (a_ov !== 1'b1 || a_data !== 24'd9) begin n_err++; $display("FAIL bp_groupA: valid=%b data=%h required 1 9", a_ov, a_data); end
        for (int i = 0; i < 8; i++) send(0, 16'd2, 1'b0);
        in_valid_v[0] = 1'b1; in_sum_v[0] = 16'd2; in_cout_v[0] = 1'b0;
        #1;
        n_cmp++; if (a_rdy !== 1'b0 || a_bz !== 1'b1) begin n_err++; $display("FAIL bp_stall: ready=%b busy=%b required 0 1", a_rdy, a_bz); end
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (a_ov !== 1'b1 || a_data !== 24'd9 || a_of !== 1'b0) begin
            n_err++; $display("FAIL bp_hold: valid=%b data=%h ovf=%b required 1 9 0", a_ov, a_data, a_of); end
        out_ready_v[0] = 1'b1;
        #1;
        n_cmp++; if (a_rdy !== 1'b1) begin n_err++; $display("FAIL bp_ready_release: got %b required 1", a_rdy); end
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0; out_ready_v[0] = 1'b0;
        n_cmp++; if (a_ov !== 1'b1 || a_data !== 24'd18 || a_bz !== 1'b0) begin
            n_err++; $display("FAIL bp_groupB: valid=%b data=%h busy=%b required 1 12 0", a_ov, a_data, a_bz); end
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b required 0", a_ov); end
    endtask

    task automatic test_clear();
        out_ready_v[0] = 1'b1;
        for (int i = 0; i < 4; i++) send(0, 16'h0100, 1'b0);
        clear_v[0] = 1'b1; in_valid_v[0] = 1'b1; in_sum_v[0] = 16'h0005;
        #1;
        n_cmp++; if (a_rdy !== 1'b0) begin n_err++; $display("FAIL clear_ready: got %b required 0", a_rdy); end
        @(posedge clk); #1;
        clear_v[0] = 1'b0; in_valid_v[0] = 1'b0;
        n_cmp++; if (a_bz !== 1'b0 || a_ov !== 1'b0) begin n_err++; $display("FAIL clear_state: busy=%b valid=%b required 0 0", a_bz, a_ov); end
        for (int i = 0; i < 9; i++) send(0, 16'h0001, 1'b0);
        n_cmp++; if (a_ov !== 1'b1 || a_data !== 24'd9) begin n_err++; $display("FAIL clear_next: valid=%b data=%h required 1 9", a_ov, a_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        out_ready_v[0] = 1'b0;
        for (int i = 0; i < 9; i++) send(0, 16'h0004, 1'b0);
        for (int i = 0; i < 5; i++) send(0, 16'h0003, 1'b0);
        n_cmp++; if (a_ov !== 1'b1 || a_bz !== 1'b1) begin n_err++; $display("FAIL arst_pre: valid=%b busy=%b required 1 1", a_ov, a_bz); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_ov !== 1'b0 || a_data !== 24'h0 || a_of !== 1'b0 || a_bz !== 1'b0) begin
            n_err++; $display("FAIL arst_clear: valid=%b data=%h ovf=%b busy=%b required all 0", a_ov, a_data, a_of, a_bz); end
        @(posedge clk); #3 rst_n = 1'b1;
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) send(0, 16'h0003, 1'b0);
        n_cmp++; if (a_ov !== 1'b1 || a_data !== 24'd27) begin n_err++; $display("FAIL arst_after: valid=%b data=%h required 1 1b", a_ov, a_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_len1();
        out_ready_v[2] = 1'b1;
        in_valid_v[2] = 1'b1; in_sum_v[2] = 16'h1234; in_cout_v[2] = 1'b0;
        @(posedge clk); #1;
        in_sum_v[2] = 16'h0000; in_cout_v[2] = 1'b1;
        n_cmp++; if (c_ov !== 1'b1 || c_data !== 24'h001234) begin n_err++; $display("FAIL len1_first: valid=%b data=%h required 1 001234", c_ov, c_data); end
        @(posedge clk); #1;
        in_valid_v[2] = 1'b0;
        n_cmp++; if (c_ov !== 1'b1 || c_data !== 24'h010000 || c_bz !== 1'b0) begin
            n_err++; $display("FAIL len1_second: valid=%b data=%h busy=%b required 1 010000 0", c_ov, c_data, c_bz); end
        @(posedge clk); #1;
        n_cmp++; if (c_ov !== 1'b0) begin n_err++; $display("FAIL len1_drop: got %b required 0", c_ov); end
    endtask

    // Random traffic on a LEN=9 instance. The model keeps the group sum as a
    // plain integer clamped at the ceiling, and the pending output as a flag.
    task automatic test_random(input int d, input int accw);
        longint unsigned maxv = (64'd1 << accw) - 1;
        longint unsigned acc = 0, tot, x, pd = 0;
        int  cnt = 0;
        bit  st = 0, pv = 0, po = 0, er, fin, o;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid_v[d]  = ($urandom_range(0, 3) != 0);
            in_sum_v[d]    = 16'($urandom);
            in_cout_v[d]   = 1'($urandom);
            out_ready_v[d] = ($urandom_range(0, 2) != 0);
            clear_v[d]     = ($urandom_range(0, 39) == 0);
            #1;
            er = !clear_v[d] && !(cnt == 8 && pv && !out_ready_v[d]);
            n_cmp++; if (rdy_v[d] !== er) begin n_err++; $display("FAIL rand_ready: inst %0d cyc %0d got %b required %b", d, cyc, rdy_v[d], er); end
            x = {in_cout_v[d], in_sum_v[d]};
            fin = 0;
            if (clear_v[d]) begin
                acc = 0; cnt = 0; st = 0;
            end else if (in_valid_v[d] && er) begin
                tot = (cnt == 0 ? 0 : acc) + x;
                o = (tot > maxv);
                if (o) tot = maxv;
                st = (cnt == 0 ? 1'b0 : st) | o;
                if (cnt == 8) begin
                    fin = 1; pd = tot; po = st; acc = 0; cnt = 0; st = 0;
                end else begin
                    acc = tot; cnt++;
                end
            end
            if (fin) pv = 1;
            else if (out_ready_v[d]) pv = 0;
            @(posedge clk); #1;
            n_cmp++; if (valid_v[d] !== pv) begin n_err++; $display("FAIL rand_valid: inst %0d cyc %0d got %b required %b", d, cyc, valid_v[d], pv); end
            if (pv) begin
                n_cmp++; if (get_data(d) !== 24'(pd) || ovf_v[d] !== po) begin
                    n_err++; $display("FAIL rand_data: inst %0d cyc %0d got %h/%b required %h/%b", d, cyc, get_data(d), ovf_v[d], 24'(pd), po); end
            end
            n_cmp++; if (busy_v[d] !== (cnt != 0)) begin n_err++; $display("FAIL rand_busy: inst %0d cyc %0d got %b required %b", d, cyc, busy_v[d], (cnt != 0)); end
        end
        in_valid_v[d] = 1'b0; clear_v[d] = 1'b0; out_ready_v[d] = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_len1();
        pulse_reset();
        test_random(0, 24);
        pulse_reset();
        test_random(1, 20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
